// File: rtl/sync_fifo_core_if.sv
// sync_fifo_core_if: producer/consumer side signals of the single-clock FIFO.
// Optional error flags exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
//
// Handshake: w_en and r_en are enable-qualified requests, not valid/ready.
// - A write is accepted on a rising edge iff w_en=1 and full=0.
// - A read is accepted on a rising edge iff r_en=1 and empty=0.
// - Requests made while blocked are dropped, never held pending.
// - Read data appears on data_out after the edge that accepts the read.
interface sync_fifo_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, overflow, underflow
  );
`else
  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty
  );
`endif
endinterface

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with full/empty flags and a registered
// read data output. DEPTH must be a power of two and at least 2.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_core_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;

  logic full_w;
  logic empty_w;
  logic wr_accept;
  logic rd_accept;

  // Flags come straight from the registered pointers.
  assign empty_w = (wptr == rptr);
  assign full_w  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // A write while full or a read while empty is simply not accepted.
  assign wr_accept = bus.w_en && !full_w;
  assign rd_accept = bus.r_en && !empty_w;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.data_out = data_out_q;

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr[AW-1:0]] <= bus.data_in;
    end
  end

  // Write pointer advances on each accepted write, wrap bit toggles naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wr_accept) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Read pointer advances on each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else if (rd_accept) begin
      rptr <= rptr + PTR_ONE;
    end
  end

  // Registered read data; holds its last value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_accept) begin
      data_out_q <= mem[rptr[AW-1:0]];
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.w_en && full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.r_en && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: directed plus random checks of sync_fifo_core against a
// queue-based reference model (optionally with SYNC_FIFO_ERR_FLAGS_EN).
module tb_sync_fifo_core;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  // Scoreboard: words accepted by the model, in write order.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic exp_ovf;
  logic exp_udf;
`endif

  sync_fifo_core_if #(.DATA_WIDTH(W)) bus ();

  sync_fifo_core #(
    .DATA_WIDTH(W),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, " data_out"}, 32'(bus.data_out), 32'(exp_dout));
    check({tag, " empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
    check({tag, " full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check({tag, " overflow"},  32'(bus.overflow),  32'(exp_ovf));
    check({tag, " underflow"}, 32'(bus.underflow), 32'(exp_udf));
`endif
  endtask

  // Driver: one clock of stimulus, model update, then check after the edge.
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit wacc;
    bit racc;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    wacc = w && (exp_q.size() < DEPTH);
    racc = r && (exp_q.size() > 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (w && exp_q.size() == DEPTH) exp_ovf = 1'b1;
    if (r && exp_q.size() == 0)     exp_udf = 1'b1;
`endif
    if (racc) exp_dout = exp_q.pop_front();
    if (wacc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    check_status(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    model_reset();

    // Reset then idle
    rst_n = 1'b0;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("reset");

    // Fill to full, then a dropped ninth write
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, W'(i), "fill");
    check("full after fill", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b0, 8'hFF, "write when full");

    // Drain in order, then an extra read that must not disturb data_out
    for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, '0, "drain");
    check("last drained word", 32'(bus.data_out), 32'h08);
    cycle(1'b0, 1'b1, '0, "read when empty");

    // Wrap: write 5, read 3, write 6 -> full, then read all
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(8'h10 + i), "wrap wr5");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "wrap rd3");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(8'h20 + i), "wrap wr6");
    check("full after wrap", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "wrap drain");

    // Simultaneous access at half full keeps occupancy
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(8'h30 + i), "half fill");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, W'(8'h40 + i), "half simul");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, "half drain");

    // Full corner: simultaneous access drops the write, accepts the read
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, W'(8'h50 + i), "refill");
    cycle(1'b1, 1'b1, 8'hAA, "full simul");
    check("full cleared by simul", 32'(bus.full), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, '0, "corner drain");

    // Empty corner: simultaneous access stores the write only, no fall-through
    cycle(1'b1, 1'b1, 8'h55, "empty simul");
    check("no fall-through", 32'(bus.data_out), 32'h57);
    cycle(1'b0, 1'b1, '0, "read 0x55");
    check("0x55 read back", 32'(bus.data_out), 32'h55);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 255)), "random");
    end

    // Reset mid-operation with 4 words stored and a nonzero data_out
    while (exp_q.size() > 0) cycle(1'b0, 1'b1, '0, "pre-reset drain");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(8'h60 + i), "pre-reset fill");
    cycle(1'b0, 1'b1, '0, "pre-reset read");
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    while (exp_q.size() < DEPTH) cycle(1'b1, 1'b0, 8'h77, "err fill");
    cycle(1'b1, 1'b0, 8'h78, "force overflow");
    while (exp_q.size() > 0) cycle(1'b0, 1'b1, '0, "err drain");
    cycle(1'b0, 1'b1, '0, "force underflow");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(8'h70 + i), "err refill4");
    check("overflow set", 32'(bus.overflow), 32'd1);
    check("underflow set", 32'(bus.underflow), 32'd1);
`endif
    check("four stored", 32'(exp_q.size()), 32'd4);
    check("empty before reset", 32'(bus.empty), 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_status("async reset");
    #2;
    check_status("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("after reset");
    cycle(1'b1, 1'b0, 8'h99, "post-reset write");
    cycle(1'b0, 1'b1, '0, "post-reset read");
    check("post-reset data", 32'(bus.data_out), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock, first-in-first-out data buffer with `full` and `empty` status flags and a registered read data output.
- Sits between a producer and a consumer that share one clock.
- Write and read are enable-qualified. Requests that would overflow or underflow the buffer are ignored.

Parameters:
- DATA_WIDTH, 8, width of each data word in bits.
- DEPTH, 8, number of storage entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_en  in  1  write request; data_in is written this cycle if not full.
- r_en  in  1  read request; the head word is popped this cycle if not empty.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  high when DEPTH words are stored.
- empty  out  1  high when 0 words are stored.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, async assert, sync release):
  - write pointer = 0, read pointer = 0, occupancy = 0.
  - data_out = 0, empty = 1, full = 0.
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all stored data immediately.
- Pointers:
  - Width is log2(DEPTH)+1 bits; the low bits index storage and the MSB is a wrap bit.
  - empty = (wptr == rptr).
  - full = (low bits equal) and (MSBs differ).
  - Both flags are combinational from the registered pointers, so they update in the same cycle the pointers update.
- Write accepted iff w_en=1 and full=0:
  - mem[wptr low bits] <= data_in; wptr increments.
  - Wrap from index DEPTH-1 to 0 toggles the wrap bit.
- Read accepted iff r_en=1 and empty=0:
  - data_out <= mem[rptr low bits]; rptr increments.
  - Latency is one cycle: data is valid on data_out after the rising edge that accepts r_en.
- Blocked requests:
  - Write while full is dropped silently; data and pointers are unchanged.
  - Read while empty is dropped; data_out holds its previous value.
- data_out holds its last read value whenever no read is accepted.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are accepted and occupancy is unchanged.
  - Full: only the read is accepted and the write is dropped. full is 0 after the edge.
  - Empty: only the write is accepted and the read is dropped. empty is 0 after the edge. There is no fall-through; data_out is not updated.
- Ordering: words are read in exactly the order they were accepted, across any number of pointer wraps.
- X handling: w_en and r_en must be known (non-X) when rst_n=1.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra 1-bit outputs are added:
  - overflow: sticky; set on the edge where w_en=1 while full=1.
  - underflow: sticky; set on the edge where r_en=1 while empty=1.
  - Both are cleared only by rst_n=0. Reset value is 0.
- When undefined, these ports and their logic do not exist. Dropped requests are silent.
- FIFO data behaviour is identical either way.

Test Plan:
- Reset then idle: rst_n=0 for 1 cycle, then release -> empty=1, full=0, data_out=0.
- Fill to full: write 0x01..0x08 on 8 consecutive cycles -> full=1 after the 8th edge, empty=0. A 9th write of 0xFF is dropped.
- Drain: 8 reads -> data_out = 0x01..0x08 in order, each one cycle after its r_en. empty=1 after the last read. A further read keeps data_out=0x08.
- Wrap and simultaneous access:
  - Write 5 words, read 3, then write 6 more -> pointers wrap and full=1.
  - Read all -> the 8 stored words appear in write order.
  - Assert w_en and r_en together while half full -> occupancy unchanged.
- Full/empty corner with simultaneous access:
  - When full, w_en=r_en=1 writes 0xAA -> the read is accepted, 0xAA is not stored, full=0.
  - When empty, w_en=r_en=1 writes 0x55 -> 0x55 is stored, data_out unchanged, empty=0.
- Reset mid-operation: with 4 words stored, pulse rst_n low between clock edges -> empty=1 and data_out=0 immediately, without waiting for a clock edge. With SYNC_FIFO_ERR_FLAGS_EN, previously set overflow/underflow clear.
